// File: rtl/adc_link_pkg.sv
// adc_link_pkg: shared constants, state encoding and slot format of the 4-lane ADC dout link
package adc_link_pkg;
    localparam int NUM_CH       = 8;
    localparam int NUM_LANES    = 4;
    localparam int SAMPLE_BITS  = 24;
    localparam int HDR_BITS     = 8;
    localparam int SLOT_BITS    = 32;
    localparam int LANE_BITS    = 2 * SLOT_BITS;
    localparam int HDR_UR_BIT   = 7;
    localparam int HDR_IDX_BITS = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_DRDY, ST_SHIFT, ST_GAP} link_state_e;

    function automatic logic [SLOT_BITS-1:0] make_slot(input logic ur, input logic [HDR_IDX_BITS-1:0] idx,
                                                       input logic [SAMPLE_BITS-1:0] sample);
        logic [HDR_BITS-1:0] hdr;
        hdr = '0;
        hdr[HDR_UR_BIT] = ur;
        hdr[HDR_IDX_BITS-1:0] = idx;
        return {hdr, sample};
    endfunction
endpackage

// File: rtl/adc_dout_emulator_if.sv
// adc_dout_emulator_if: ADC data-out link (frame strobe, data clock, data lanes)
interface adc_dout_emulator_if;
    import adc_link_pkg::*;
    logic                 drdy;
    logic                 dclk;
    logic [NUM_LANES-1:0] dout;
    modport master (output drdy, dclk, dout);
    modport slave (input drdy, dclk, dout);
endinterface

// File: rtl/adc_dclk_gen.sv
// adc_dclk_gen: registered dclk divider for the shift phase, with a fall strobe one clk ahead
module adc_dclk_gen #(
    parameter int DCLK_DIV = 4
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic run_i,
    output logic dclk_o,
    output logic fall_o
);
    localparam int CW = $clog2(DCLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(DCLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DCLK_DIV / 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dclk_q, dclk_d;

    // parking at LAST makes the first shift cycle land on phase 0
    always_comb begin
        cnt_d  = !run_i ? LAST : (cnt_q == LAST ? '0 : cnt_q + 1'b1);
        dclk_d = run_i && cnt_d >= HALF;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q  <= LAST;
            dclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dclk_q <= dclk_d;
        end
    end

    assign dclk_o = dclk_q;
    assign fall_o = dclk_q && !dclk_d;
endmodule

// File: rtl/adc_dout_emulator.sv
// adc_dout_emulator: ADC-side transmitter of the 4-lane dout link, framing synthetic samples
module adc_dout_emulator
    import adc_link_pkg::*;
#(
    parameter int FRAME_PERIOD = 781,
    parameter int DCLK_DIV     = 4
) (
    input  logic                                clk_i,
    input  logic                                reset_ni,
    input  logic                                enable_i,
    input  logic                                sample_valid_i,
    input  logic [NUM_CH-1:0][SAMPLE_BITS-1:0]  ch_i,
    output logic                                sample_ready_o,
    output logic                                frame_tick_o,
    output logic                                underrun_o,
    adc_dout_emulator_if.master                 link
);
    localparam int TW = $clog2(FRAME_PERIOD);
    localparam logic [TW-1:0] T_DRDY_END  = TW'(DCLK_DIV - 1);
    localparam logic [TW-1:0] T_SHIFT_END = TW'(DCLK_DIV * 65 - 1);
    localparam logic [TW-1:0] T_FRAME_END = TW'(FRAME_PERIOD - 1);

    link_state_e                         state_q, state_d;
    logic [TW-1:0]                       timer_q, timer_d;
    logic [NUM_CH-1:0][SAMPLE_BITS-1:0]  shadow_q, shadow_d;
    logic [NUM_LANES-1:0][LANE_BITS-1:0] lane_q, lane_d;
    logic [1:0]                          rst_sync_q, rst_sync_d;
    logic ur_frame_q, ur_frame_d, underrun_q, underrun_d, drdy_q, drdy_d;
    logic rst_n, frame_start, load, fall;

    assign rst_n = rst_sync_q[1];

    adc_dclk_gen #(.DCLK_DIV(DCLK_DIV)) u_dclk (
        .clk_i,
        .reset_ni(rst_n),
        .run_i(state_d == ST_SHIFT),
        .dclk_o(link.dclk),
        .fall_o(fall)
    );

    always_comb begin
        rst_sync_d  = {rst_sync_q[0], 1'b1};
        frame_start = state_q == ST_DRDY && timer_q == '0;
        load        = state_q == ST_DRDY && timer_q == T_DRDY_END;
        state_d     = state_q;
        case (state_q)
            ST_IDLE:  state_d = enable_i ? ST_DRDY : ST_IDLE;
            ST_DRDY:  state_d = load ? ST_SHIFT : ST_DRDY;
            ST_SHIFT: state_d = timer_q == T_SHIFT_END ? ST_GAP : ST_SHIFT;
            default:  state_d = timer_q == T_FRAME_END ? (enable_i ? ST_DRDY : ST_IDLE) : ST_GAP;
        endcase
        timer_d    = (state_q == ST_IDLE || timer_q == T_FRAME_END) ? '0 : timer_q + 1'b1;
        shadow_d   = frame_start && sample_valid_i ? ch_i : shadow_q;
        ur_frame_d = frame_start ? !sample_valid_i : ur_frame_q;
        underrun_d = underrun_q || (frame_start && !sample_valid_i);
        drdy_d     = state_d == ST_DRDY;
    end

    // 64 falls per frame, the last on SHIFT exit, leave every lane empty so dout idles at 0
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [LANE_BITS-1:0] load_val;
        assign load_val = {make_slot(ur_frame_q, HDR_IDX_BITS'(2 * k), shadow_q[2 * k]),
                           make_slot(ur_frame_q, HDR_IDX_BITS'(2 * k + 1), shadow_q[2 * k + 1])};
        assign lane_d[k] = load ? load_val : fall ? {lane_q[k][LANE_BITS-2:0], 1'b0} : lane_q[k];
        assign link.dout[k] = lane_q[k][LANE_BITS-1];
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) rst_sync_q <= '0;
        else rst_sync_q <= rst_sync_d;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            shadow_q   <= '0;
            lane_q     <= '0;
            ur_frame_q <= 1'b0;
            underrun_q <= 1'b0;
            drdy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            shadow_q   <= shadow_d;
            lane_q     <= lane_d;
            ur_frame_q <= ur_frame_d;
            underrun_q <= underrun_d;
            drdy_q     <= drdy_d;
        end
    end

    assign link.drdy      = drdy_q;
    assign sample_ready_o = frame_start && sample_valid_i;
    assign frame_tick_o   = frame_start;
    assign underrun_o     = underrun_q;
endmodule

// File: tb/tb_adc_dout_emulator.sv
// tb_adc_dout_emulator: directed frame, underrun, enable and reset checks for the dout emulator
module tb_adc_dout_emulator;
    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             enable = 1'b0;
    logic             valid = 1'b0;
    logic [7:0][23:0] ch = '0;
    logic             sample_ready_o, frame_tick_o, underrun_o;
    logic             ready2, tick2, ur2;
    int               errors = 0, checks = 0;

    adc_dout_emulator_if lk ();
    adc_dout_emulator_if lk2 ();

    adc_dout_emulator dut (
        .clk_i(clk), .reset_ni(reset_n), .enable_i(enable), .sample_valid_i(valid), .ch_i(ch),
        .sample_ready_o(sample_ready_o), .frame_tick_o(frame_tick_o), .underrun_o(underrun_o), .link(lk)
    );

    adc_dout_emulator #(.FRAME_PERIOD(132), .DCLK_DIV(2)) dut2 (
        .clk_i(clk), .reset_ni(reset_n), .enable_i(enable), .sample_valid_i(valid), .ch_i(ch),
        .sample_ready_o(ready2), .frame_tick_o(tick2), .underrun_o(ur2), .link(lk2)
    );

    always #5 clk = ~clk;

    logic [3:0][63:0] cap = '0;
    logic [3:0]       dout_p = '0, dout2_p = '0;
    logic             dclk_p = 1'b0, drdy_p = 1'b0, rstn_p = 1'b0, dclk2_p = 1'b0, drdy2_p = 1'b0;
    int               cyc = 0, nbits = 0, last_rise = -1, spacing = 0, edge_bad = 0;
    int               last_rise2 = -1, spacing2 = 0, edge_bad2 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // receiver model: sample lanes on dclk rise, measure drdy spacing, flag dout edges off a dclk fall
    always @(negedge clk) begin
        if (lk.dclk && !dclk_p) begin
            for (int k = 0; k < 4; k++) cap[k] <= {cap[k][62:0], lk.dout[k]};
            nbits <= nbits + 1;
        end
        if (lk.drdy && !drdy_p) begin
            nbits <= 0;
            if (last_rise >= 0) spacing <= cyc - last_rise;
            last_rise <= cyc;
        end
        if (reset_n && rstn_p && lk.dout != dout_p && !(dclk_p && !lk.dclk) && !drdy_p) edge_bad <= edge_bad + 1;
        dclk_p <= lk.dclk;
        drdy_p <= lk.drdy;
        dout_p <= lk.dout;
        rstn_p <= reset_n;
    end

    always @(negedge clk) begin
        if (lk2.drdy && !drdy2_p) begin
            if (last_rise2 >= 0) spacing2 <= cyc - last_rise2;
            last_rise2 <= cyc;
        end
        if (reset_n && rstn_p && lk2.dout != dout2_p && !(dclk2_p && !lk2.dclk) && !drdy2_p) edge_bad2 <= edge_bad2 + 1;
        dclk2_p <= lk2.dclk;
        drdy2_p <= lk2.drdy;
        dout2_p <= lk2.dout;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_tick(input int budget, output logic found, output int w);
        found = 1'b0;
        w = 0;
        while (!found && w < budget) begin
            @(negedge clk);
            w++;
            found = frame_tick_o;
        end
    endtask

    function automatic logic [63:0] exp_lane(input logic ur, input int k, input logic [7:0][23:0] d);
        logic [7:0] h0, h1;
        h0 = {ur, 4'b0000, 3'(2 * k)};
        h1 = {ur, 4'b0000, 3'(2 * k + 1)};
        return {h0, d[2 * k], h1, d[2 * k + 1]};
    endfunction

    initial begin
        logic             found;
        int               w;
        logic [7:0][23:0] e_set, j_set, z_set;
        logic [63:0]      f1_exp [4];
        f1_exp = '{64'h00010101_01020202, 64'h02030303_03040404, 64'h04050505_05060606, 64'h06070707_07080808};
        e_set  = {24'hFEDCBA, 24'h123456, 24'h5A5A5A, 24'hA5A5A5, 24'h000001, 24'hFFFFFF, 24'h7FFFFF, 24'h800000};
        z_set  = '0;
        for (int i = 0; i < 8; i++) j_set[i] = 24'((i + 1) * 24'h0A0B0C);
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_drdy", lk.drdy, 0);
        check("rst_dclk", lk.dclk, 0);
        check("rst_dout", lk.dout, 0);
        check("rst_flags", {underrun_o, sample_ready_o, frame_tick_o}, 0);
        for (int i = 0; i < 8; i++) ch[i] = 24'((i + 1) * 24'h010101);
        valid = 1'b1;
        enable = 1'b1;
        reset_n = 1'b1;
        wait_tick(20, found, w);
        check("f1_tick", found, 1);
        check("f1_ready", sample_ready_o, 1);
        @(negedge clk);
        check("f1_ready_pulse", sample_ready_o, 0);
        repeat (299) @(negedge clk);
        for (int k = 0; k < 4; k++) check($sformatf("f1_lane%0d", k), cap[k], f1_exp[k]);
        check("f1_nbits", nbits, 64);
        check("f1_underrun", underrun_o, 0);
        ch = e_set;
        wait_tick(1000, found, w);
        check("f2_tick", found, 1);
        repeat (10) @(negedge clk);
        ch = j_set;
        repeat (290) @(negedge clk);
        for (int k = 0; k < 4; k++) check($sformatf("f2_lane%0d", k), cap[k], exp_lane(1'b0, k, e_set));
        check("drdy_spacing", spacing, 781);
        check("drdy_spacing_div2", spacing2, 132);
        valid = 1'b0;
        wait_tick(1000, found, w);
        check("f3_tick", found, 1);
        check("f3_ready", sample_ready_o, 0);
        repeat (300) @(negedge clk);
        for (int k = 0; k < 4; k++) check($sformatf("f3_lane%0d", k), cap[k], exp_lane(1'b1, k, e_set));
        check("f3_underrun", underrun_o, 1);
        valid = 1'b1;
        wait_tick(1000, found, w);
        check("f4_tick", found, 1);
        check("f4_ready", sample_ready_o, 1);
        repeat (300) @(negedge clk);
        for (int k = 0; k < 4; k++) check($sformatf("f4_lane%0d", k), cap[k], exp_lane(1'b0, k, j_set));
        check("f4_underrun_sticky", underrun_o, 1);
        wait_tick(1000, found, w);
        check("f5_tick", found, 1);
        repeat (44) @(negedge clk);
        enable = 1'b0;
        repeat (256) @(negedge clk);
        check("f5_nbits", nbits, 64);
        for (int k = 0; k < 4; k++) check($sformatf("f5_lane%0d", k), cap[k], exp_lane(1'b0, k, j_set));
        wait_tick(1500, found, w);
        check("idle_no_tick", found, 0);
        check("idle_outputs", {lk.drdy, lk.dclk, lk.dout}, 0);
        enable = 1'b1;
        @(negedge clk);
        check("idle_to_drdy", frame_tick_o, 1);
        repeat (44) @(negedge clk);
        enable = 1'b0;
        repeat (356) @(negedge clk);
        enable = 1'b1;
        wait_tick(1000, found, w);
        check("gap_reenable_tick", found, 1);
        check("gap_reenable_spacing", 400 + w, 781);
        repeat (166) @(negedge clk);
        check("pre_rst_dclk", lk.dclk, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_link", {lk.drdy, lk.dclk, lk.dout}, 0);
        check("async_rst_flags", {underrun_o, sample_ready_o, frame_tick_o}, 0);
        repeat (3) @(negedge clk);
        valid = 1'b0;
        reset_n = 1'b1;
        wait_tick(20, found, w);
        check("post_rst_tick", found, 1);
        check("post_rst_ready", sample_ready_o, 0);
        repeat (300) @(negedge clk);
        for (int k = 0; k < 4; k++) check($sformatf("post_rst_lane%0d", k), cap[k], exp_lane(1'b1, k, z_set));
        check("post_rst_underrun", underrun_o, 1);
        check("dout_edges", edge_bad, 0);
        check("dout_edges_div2", edge_bad2, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
